// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and store-lane helpers for the LSU
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R
   } lsu_state_t;

   // Loads always fetch the full word; only stores narrow the byte enables.
   function automatic logic [3:0] be_gen(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      if (is_store) begin
         case (funct3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] wdata_gen(input logic [2:0] funct3, input logic [31:0] d);
      logic [31:0] w;
      case (funct3)
         F3_B:    w = {4{d[7:0]}};
         F3_H:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword of a read word and extends it
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'h00;
      case (off)
         2'd0: lane_b = rdata[7:0];
         2'd1: lane_b = rdata[15:8];
         2'd2: lane_b = rdata[23:16];
         2'd3: lane_b = rdata[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   data = {24'h000000, lane_b};
         F3_H:    data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   data = {16'h0000, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: one outstanding req/gnt/rvalid access, stalls upstream
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] StoreData,
   output logic                  lsu_busy,
   output logic                  ld_valid,
   output logic [DATA_WIDTH-1:0] ld_data,
   output logic                  lsu_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_t            state, state_n;
   logic                  req_n, we_n, ld_valid_n, err_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] wdata_n, ld_data_n, align_data;
   logic [3:0]            be_n;
   logic [2:0]            lat_f3, lat_f3_n;
   logic [1:0]            lat_off, lat_off_n;
   logic                  accept, op_bad, misaligned;

   lsu_load_align u_align (
      .rdata  (mem_rdata),
      .off    (lat_off),
      .funct3 (lat_f3),
      .data   (align_data)
   );

   assign lsu_busy = (state != IDLE);
   assign accept   = ex_valid & (MemRead | MemWrite);

   // Misalignment follows access size in funct3[1:0]; illegal codes are already caught by op_bad.
   assign misaligned = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                       ((Funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
   assign op_bad = (MemRead & MemWrite) |
                   (MemRead & ((Funct3 == 3'b011) | (Funct3[2:1] == 2'b11))) |
                   (MemWrite & (Funct3 > F3_W)) |
                   misaligned;

   always_comb begin
      state_n    = state;
      req_n      = mem_req;
      we_n       = mem_we;
      addr_n     = mem_addr;
      wdata_n    = mem_wdata;
      be_n       = mem_be;
      ld_valid_n = 1'b0;
      ld_data_n  = ld_data;
      err_n      = 1'b0;
      lat_f3_n   = lat_f3;
      lat_off_n  = lat_off;

      case (state)
         IDLE: begin
            if (accept) begin
               if (op_bad) begin
                  err_n = 1'b1;
               end else begin
                  state_n   = REQ;
                  req_n     = 1'b1;
                  we_n      = MemWrite;
                  addr_n    = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                  be_n      = be_gen(MemWrite, Funct3, ALUResult[1:0]);
                  wdata_n   = MemWrite ? wdata_gen(Funct3, StoreData) : '0;
                  lat_f3_n  = Funct3;
                  lat_off_n = ALUResult[1:0];
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               req_n   = 1'b0;
               state_n = mem_we ? IDLE : WAIT_R;
            end
         end
         WAIT_R: begin
            if (mem_rvalid) begin
               ld_data_n  = align_data;
               ld_valid_n = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= 4'b0000;
         ld_valid  <= 1'b0;
         ld_data   <= '0;
         lsu_err   <= 1'b0;
         lat_f3    <= 3'b000;
         lat_off   <= 2'b00;
      end else begin
         state     <= state_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         mem_be    <= be_n;
         ld_valid  <= ld_valid_n;
         ld_data   <= ld_data_n;
         lsu_err   <= err_n;
         lat_f3    <= lat_f3_n;
         lat_off   <= lat_off_n;
      end
   end

endmodule
